uart_tx_controller: RTL and testbench
=====================================

Name: uart_tx_controller

Overview:
- Transmit-side counterpart of the MIPS UART receive path: accepts a 32-bit store from the CPU bus and serialises one byte as 8N1, LSB first, on SerialDataOut.
- Optional binary-to-ASCII encoding of a hex digit, the inverse of the receive-side translator.
- One-entry holding register, so software can queue one byte while another is shifting.
- Busy and done status are zero-extended to DATA_WIDTH for direct readback by the MIPS core.

Parameters:
DATA_WIDTH, 32, bus word width.
UART_Nbit, 8, data bits per frame.
baudrate, 5, line rate (sim default; silicon 9600).
clk_freq, 50, clock frequency (sim default; silicon 50000000).
CLKS_PER_BIT (localparam), clk_freq/baudrate (integer division, must be >=2), clocks per bit; 10 at defaults.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
tx_wr  in  1  write strobe, one-cycle pulse, samples uart_tx.
uart_tx  in  DATA_WIDTH  write data; [7:0] used (raw mode), [3:0] used (ASCII mode), rest ignored.
ascii_en  in  1  1 = encode uart_tx[3:0] to ASCII hex; 0 = send uart_tx[7:0] raw.
clr_tx_flag  in  1  active-high, one-cycle clear of the done flag.
SerialDataOut  out  1  serial line; idle high.
Tx_busy_out  out  DATA_WIDTH  {31'b0, hold_full}.
Tx_flag_out  out  DATA_WIDTH  {31'b0, tx_done}.

Behaviour:
- Reset (sync, highest priority, any state incl. mid-frame):
  - FSM=IDLE, SerialDataOut=1, hold_full=0, tx_done=0.
  - Baud counter and bit index are 0; holding and shift registers are 0.
  - The in-flight frame is aborted and the line is high from the cycle after the reset edge.
- Encoding (sampled with tx_wr):
  - ascii_en=0: byte = uart_tx[7:0].
  - ascii_en=1: n = uart_tx[3:0]; n 0-9 -> 8'h30+n; n 10-15 -> 8'h41+(n-10) (uppercase).
- Write acceptance:
  - tx_wr=1 and hold_full=0: holding <= encoded byte, hold_full <= 1.
  - tx_wr=1 and hold_full=1: write dropped; holding unchanged, no error flag. Software polls Tx_busy_out.
  - Same-cycle write while the FSM drains the holding register (hold_full=1 at that edge) is dropped.
- FSM (all outputs registered):
  - IDLE: line=1. If hold_full: shift <= holding, hold_full <= 0, go to START, counter=0.
  - START: line=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: line=shift[index] for CLKS_PER_BIT cycles each. Index 0..7, LSB first. After index 7, go to STOP.
  - STOP: line=1 for CLKS_PER_BIT cycles. On the last cycle (counter==CLKS_PER_BIT-1), tx_done <= 1, then:
    - if hold_full: load shift from holding, clear hold_full, go directly to START (no idle gap).
    - otherwise go to IDLE.
- Latency: write at edge k -> hold_full=1 after k -> START and line=0 after edge k+1. Frame length is exactly 10*CLKS_PER_BIT cycles.
- Baud counter: counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary, held at 0 in IDLE.
- tx_done is sticky until clr_tx_flag. Set and clear in the same cycle: set wins. clr_tx_flag with tx_done=0 has no effect.
- tx_wr has no effect on an in-flight frame; the shift register changes only at START entry.

Test Plan:
- Reset, then write 0x0000_0055 with ascii_en=0 at cycle 0 -> line=1 at cycle 1; line low cycles 2-11; bits 1,0,1,0,1,0,1,0 each 10 cycles; high cycles 92-101; Tx_flag_out=1 after cycle 101; Tx_busy_out=1 only during cycle 1.
- ASCII mode: uart_tx=0x0000_0007 -> frame byte 0x37; uart_tx=0xFFFF_FF0C -> 0x43.
- Back-to-back: write 0xA1, then 0xB2 while 0xA1 is in DATA -> Tx_busy_out=1 until 0xB2 is loaded. 0xB2 start bit begins the cycle after 0xA1's last stop cycle, with no idle gap. A third write while busy is dropped: only 0xA1 and 0xB2 appear on the line.
- Flag handling: clr_tx_flag pulsed on the same edge tx_done sets -> Tx_flag_out stays 1; a later clr pulse -> 0.
- Reset asserted mid-DATA (bit 4) -> SerialDataOut=1, Tx_busy_out=0, Tx_flag_out=0 next cycle; a new write afterwards produces a clean full frame.
- Edge encodings: ascii_en=1 with nibble 0x0 -> 0x30, 0x9 -> 0x39, 0xA -> 0x41, 0xF -> 0x46. ascii_en=0 with 0x00 and 0xFF -> correct frames.

Source files
------------

// File: rtl/uart_tx_controller.sv
// 8N1 UART transmitter for the MIPS bus: one-entry holding register in front of a
// shift register, optional hex-nibble to ASCII encoding, sticky done flag.
module uart_tx_controller #(
    parameter int DATA_WIDTH = 32,
    parameter int UART_Nbit  = 8,
    parameter int baudrate   = 5,
    parameter int clk_freq   = 50
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tx_wr,
    input  logic [DATA_WIDTH-1:0] uart_tx,
    input  logic                  ascii_en,
    input  logic                  clr_tx_flag,
    output logic                  SerialDataOut,
    output logic [DATA_WIDTH-1:0] Tx_busy_out,
    output logic [DATA_WIDTH-1:0] Tx_flag_out
);

    localparam int CLKS_PER_BIT = clk_freq / baudrate;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (UART_Nbit > 1) ? $clog2(UART_Nbit) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [IW-1:0]        idx_q;
    logic [UART_Nbit-1:0] hold_q;
    logic [UART_Nbit-1:0] shift_q;
    logic                 hold_full_q;
    logic                 done_q;
    logic                 line_q;

    logic [3:0]           nib;
    logic [7:0]           asc;
    logic [UART_Nbit-1:0] hold_d;
    logic                 bit_end;
    logic                 drain;

    // 10..15 map to 'A'..'F': 8'h41 + (n - 10) == 8'h37 + n
    always_comb begin
        nib     = uart_tx[3:0];
        asc     = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
        hold_d  = ascii_en ? UART_Nbit'(asc) : uart_tx[UART_Nbit-1:0];
        bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));
        drain   = hold_full_q && ((state_q == IDLE) || (state_q == STOP && bit_end));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            hold_q      <= '0;
            shift_q     <= '0;
            hold_full_q <= 1'b0;
            done_q      <= 1'b0;
            line_q      <= 1'b1;
        end else begin
            // A write landing on the drain edge still sees hold_full=1 and is dropped
            if (drain)
                hold_full_q <= 1'b0;
            else if (tx_wr && !hold_full_q) begin
                hold_q      <= hold_d;
                hold_full_q <= 1'b1;
            end

            if (state_q == STOP && bit_end)
                done_q <= 1'b1;
            else if (clr_tx_flag)
                done_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    cnt_q  <= '0;
                    line_q <= 1'b1;
                    if (hold_full_q) begin
                        shift_q <= hold_q;
                        state_q <= START;
                        line_q  <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        state_q <= DATA;
                        line_q  <= shift_q[0];
                    end else
                        cnt_q <= cnt_q + CW'(1);
                end
                DATA: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (idx_q == IW'(UART_Nbit - 1)) begin
                            state_q <= STOP;
                            line_q  <= 1'b1;
                        end else begin
                            idx_q  <= idx_q + IW'(1);
                            line_q <= shift_q[idx_q + IW'(1)];
                        end
                    end else
                        cnt_q <= cnt_q + CW'(1);
                end
                STOP: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        // Chain straight into the next frame when a byte is waiting
                        if (hold_full_q) begin
                            shift_q <= hold_q;
                            state_q <= START;
                            line_q  <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            line_q  <= 1'b1;
                        end
                    end else
                        cnt_q <= cnt_q + CW'(1);
                end
                default: begin
                    state_q <= IDLE;
                    line_q  <= 1'b1;
                end
            endcase
        end
    end

    assign SerialDataOut = line_q;
    assign Tx_busy_out   = {{(DATA_WIDTH-1){1'b0}}, hold_full_q};
    assign Tx_flag_out   = {{(DATA_WIDTH-1){1'b0}}, done_q};

endmodule

// File: tb/tb_uart_tx_controller.sv
// Bench for uart_tx_controller: a line monitor decodes frames and checks them against
// a queue of expected bytes; the main process checks cycle-exact latency, flags and reset.
module tb_uart_tx_controller;

    localparam int CPB = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        tx_wr;
    logic [31:0] uart_tx;
    logic        ascii_en;
    logic        clr_tx_flag;
    logic        SerialDataOut;
    logic [31:0] Tx_busy_out;
    logic [31:0] Tx_flag_out;

    int          n_chk = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];
    logic        abort_mon = 1'b0;
    logic        mon_prev;
    logic        mon_abort;
    logic [7:0]  mon_byte;
    logic [7:0]  exp_b;

    logic [31:0] vd [8] = '{32'h0000_0007, 32'hFFFF_FF0C, 32'h0, 32'h9, 32'hA, 32'hF, 32'h00, 32'hFF};
    logic        va [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0]  ve [8] = '{8'h37, 8'h43, 8'h30, 8'h39, 8'h41, 8'h46, 8'h00, 8'hFF};

    uart_tx_controller dut (
        .clk          (clk),
        .reset        (reset),
        .tx_wr        (tx_wr),
        .uart_tx      (uart_tx),
        .ascii_en     (ascii_en),
        .clr_tx_flag  (clr_tx_flag),
        .SerialDataOut(SerialDataOut),
        .Tx_busy_out  (Tx_busy_out),
        .Tx_flag_out  (Tx_flag_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives a one-cycle write at the current negedge; returns one negedge later.
    task automatic wr(input logic [31:0] d, input logic a, input logic push, input logic [7:0] e);
        tx_wr = 1'b1; uart_tx = d; ascii_en = a;
        if (push) exp_q.push_back(e);
        @(negedge clk);
        tx_wr = 1'b0; uart_tx = '0; ascii_en = 1'b0;
    endtask

    task automatic clr_pulse();
        clr_tx_flag = 1'b1;
        @(negedge clk);
        clr_tx_flag = 1'b0;
    endtask

    // Line monitor: mid-bit sampling from the first low cycle of each frame
    initial begin
        mon_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (abort_mon) begin
                abort_mon = 1'b0;
                mon_prev  = 1'b1;
            end else if (mon_prev && !SerialDataOut && !reset) begin
                mon_abort = 1'b0;
                mon_byte  = '0;
                for (int k = 1; k < 10*CPB; k++) begin
                    @(negedge clk);
                    if (abort_mon) begin
                        abort_mon = 1'b0;
                        mon_abort = 1'b1;
                        break;
                    end
                    if (k == CPB/2)
                        chk("start_bit", {31'b0, SerialDataOut}, 32'd0);
                    else if (k == 9*CPB + CPB/2)
                        chk("stop_bit", {31'b0, SerialDataOut}, 32'd1);
                    else if (k % CPB == CPB/2)
                        mon_byte[3'(k/CPB - 1)] = SerialDataOut;
                end
                if (!mon_abort) begin
                    chk("frame_expected", {31'b0, exp_q.size() != 0}, 32'd1);
                    if (exp_q.size() != 0) begin
                        exp_b = exp_q.pop_front();
                        chk("frame_byte", {24'b0, mon_byte}, {24'b0, exp_b});
                    end
                end
                mon_prev = mon_abort ? 1'b1 : SerialDataOut;
            end else
                mon_prev = SerialDataOut;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err + 1);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; tx_wr = 1'b0; uart_tx = '0; ascii_en = 1'b0; clr_tx_flag = 1'b0;
        cyc(3);
        chk("rst_line", {31'b0, SerialDataOut}, 32'd1);
        chk("rst_busy", Tx_busy_out, 32'd0);
        chk("rst_flag", Tx_flag_out, 32'd0);
        reset = 1'b0;
        cyc(2);

        // Cycle-exact frame of 0x55
        wr(32'h0000_0055, 1'b0, 1'b1, 8'h55);
        chk("t1_busy_c1", Tx_busy_out, 32'd1);
        chk("t1_line_c1", {31'b0, SerialDataOut}, 32'd1);
        for (int c = 2; c <= 102; c++) begin
            @(negedge clk);
            if (c == 2)   chk("t1_busy_c2", Tx_busy_out, 32'd0);
            if (c == 2)   chk("t1_line_c2", {31'b0, SerialDataOut}, 32'd0);
            if (c == 11)  chk("t1_line_c11", {31'b0, SerialDataOut}, 32'd0);
            if (c == 12)  chk("t1_line_c12", {31'b0, SerialDataOut}, 32'd1);
            if (c == 22)  chk("t1_line_c22", {31'b0, SerialDataOut}, 32'd0);
            if (c == 91)  chk("t1_line_c91", {31'b0, SerialDataOut}, 32'd0);
            if (c == 92)  chk("t1_line_c92", {31'b0, SerialDataOut}, 32'd1);
            if (c == 101) chk("t1_flag_c101", Tx_flag_out, 32'd0);
            if (c == 102) chk("t1_flag_c102", Tx_flag_out, 32'd1);
        end
        cyc(3);

        // Encoding table: ASCII digits/letters and raw extremes
        for (int i = 0; i < 8; i++) begin
            clr_pulse();
            chk("tbl_flag_clr", Tx_flag_out, 32'd0);
            wr(vd[i], va[i], 1'b1, ve[i]);
            cyc(103);
            chk("tbl_flag_set", Tx_flag_out, 32'd1);
        end

        // Clear on the same edge the done flag sets: set wins
        clr_pulse();
        wr(32'h5A, 1'b0, 1'b1, 8'h5A);
        for (int c = 2; c <= 102; c++) begin
            @(negedge clk);
            if (c == 101) clr_tx_flag = 1'b1;
            if (c == 102) begin
                clr_tx_flag = 1'b0;
                chk("flag_set_wins", Tx_flag_out, 32'd1);
            end
        end
        cyc(2);
        clr_pulse();
        chk("flag_late_clr", Tx_flag_out, 32'd0);
        cyc(3);

        // Back-to-back: 0xB2 queued during 0xA1, 0xC3 dropped
        wr(32'hA1, 1'b0, 1'b1, 8'hA1);
        for (int c = 2; c <= 102; c++) begin
            @(negedge clk);
            if (c == 30) begin
                tx_wr = 1'b1; uart_tx = 32'hB2; exp_q.push_back(8'hB2);
            end
            if (c == 31) begin
                chk("b2b_busy_c31", Tx_busy_out, 32'd1);
                uart_tx = 32'hC3;
            end
            if (c == 32) begin
                tx_wr = 1'b0; uart_tx = '0;
            end
            if (c == 101) chk("b2b_busy_c101", Tx_busy_out, 32'd1);
            if (c == 101) chk("b2b_line_c101", {31'b0, SerialDataOut}, 32'd1);
            if (c == 102) chk("b2b_busy_c102", Tx_busy_out, 32'd0);
            if (c == 102) chk("b2b_line_c102", {31'b0, SerialDataOut}, 32'd0);
        end
        cyc(105);

        // Reset during data bit 4, then a clean frame
        wr(32'h96, 1'b0, 1'b1, 8'h96);
        cyc(56);
        reset = 1'b1; abort_mon = 1'b1;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_line", {31'b0, SerialDataOut}, 32'd1);
        chk("mid_rst_busy", Tx_busy_out, 32'd0);
        chk("mid_rst_flag", Tx_flag_out, 32'd0);
        cyc(20);
        chk("mid_rst_idle", {31'b0, SerialDataOut}, 32'd1);
        wr(32'h3C, 1'b0, 1'b1, 8'h3C);
        cyc(105);

        chk("all_frames_seen", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
